// File: rtl/step_pkg.sv
// step_pkg: shared state/owner encodings and timing defaults for the step scheduler.
package step_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DIR_SETUP, ST_STEP_HI, ST_STEP_LO} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_TRK = 2'd1, OWN_MAN = 2'd2} owner_e;
  localparam int DEF_WIDTH_WORK    = 16;
  localparam int DEF_PULSE_HI_CYC  = 100;
  localparam int DEF_DIR_SETUP_CYC = 250;
  localparam int DEF_MIN_PERIOD    = 500;
endpackage

// File: rtl/step_timer.sv
// step_timer: loadable phase down-counter that stops at zero and flags it.
module step_timer
  import step_pkg::*;
#(
  parameter int W = DEF_WIDTH_WORK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/step_sched.sv
// step_sched: arbitrates a tracking and a manual requester onto one step/dir driver,
// with dir setup time, fixed pulse width and clamped step period.
module step_sched
  import step_pkg::*;
#(
  parameter int WIDTH_WORK    = DEF_WIDTH_WORK,
  parameter int PULSE_HI_CYC  = DEF_PULSE_HI_CYC,
  parameter int DIR_SETUP_CYC = DEF_DIR_SETUP_CYC,
  parameter int MIN_PERIOD    = DEF_MIN_PERIOD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trk_en,
  input  logic                  trk_dir,
  input  logic [WIDTH_WORK-1:0] trk_period,
  input  logic                  man_req,
  input  logic                  man_dir,
  input  logic [WIDTH_WORK-1:0] man_period,
  input  logic [WIDTH_WORK-1:0] man_steps,
  output logic                  man_busy,
  output logic                  man_done,
  output logic                  step,
  output logic                  dir,
  output logic                  drv_enable,
  output logic [1:0]            owner,
  output logic [WIDTH_WORK-1:0] step_cnt
);
  localparam logic [WIDTH_WORK-1:0] MIN_P    = WIDTH_WORK'(MIN_PERIOD);
  localparam logic [WIDTH_WORK-1:0] SETUP_LD = WIDTH_WORK'(DIR_SETUP_CYC - 1);
  localparam logic [WIDTH_WORK-1:0] HI_LD    = WIDTH_WORK'(PULSE_HI_CYC - 1);
  localparam logic [WIDTH_WORK-1:0] LO_OFS   = WIDTH_WORK'(PULSE_HI_CYC + 1);
  state_e state_q, state_d;
  owner_e owner_q, owner_d, req_own;
  logic dir_q, dir_d, pend_q, pend_d, pdir_q, pdir_d, busy_q, busy_d;
  logic done_q, done_d, step_q, step_d, drv_q, drv_d;
  logic [WIDTH_WORK-1:0] per_q, per_d, rem_q, rem_d, pper_q, pper_d;
  logic [WIDTH_WORK-1:0] psteps_q, psteps_d, cnt_q, cnt_d, req_per, t_val;
  logic man_cont, req_dir, lo_end, arb, same, finish, accept, hi_entry, t_load, t_zero;
  function automatic logic [WIDTH_WORK-1:0] clamp(input logic [WIDTH_WORK-1:0] p);
    return p < MIN_P ? MIN_P : p;
  endfunction
  // A manual move with steps left keeps the driver; otherwise pending manual beats tracking.
  assign man_cont = owner_q == OWN_MAN && rem_q != '0;
  assign req_own  = (man_cont || pend_q) ? OWN_MAN : trk_en ? OWN_TRK : OWN_NONE;
  assign req_dir  = man_cont ? dir_q : pend_q ? pdir_q : trk_dir;
  assign req_per  = man_cont ? per_q : clamp(pend_q ? pper_q : trk_period);
  assign lo_end   = state_q == ST_STEP_LO && t_zero;
  assign arb      = state_q == ST_IDLE || lo_end;
  assign same     = lo_end && req_own == owner_q && req_dir == dir_q;
  assign finish   = lo_end && owner_q == OWN_MAN && rem_q == '0;
  assign accept   = man_req && !busy_q;
  assign hi_entry = state_d == ST_STEP_HI && state_q != ST_STEP_HI;
  assign t_load   = state_d != state_q;
  assign t_val    = state_d == ST_DIR_SETUP ? SETUP_LD : state_d == ST_STEP_HI ? HI_LD : per_q - LO_OFS;
  step_timer #(.W(WIDTH_WORK)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (t_load),
    .val_i  (t_val),
    .zero_o (t_zero)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = req_own != OWN_NONE ? ST_DIR_SETUP : ST_IDLE;
      ST_DIR_SETUP: state_d = t_zero ? ST_STEP_HI : ST_DIR_SETUP;
      ST_STEP_HI:   state_d = t_zero ? ST_STEP_LO : ST_STEP_HI;
      default:      state_d = !t_zero ? ST_STEP_LO : req_own == OWN_NONE ? ST_IDLE : same ? ST_STEP_HI : ST_DIR_SETUP;
    endcase
  end
  always_comb begin
    owner_d  = arb ? req_own : owner_q;
    dir_d    = arb && req_own != OWN_NONE ? req_dir : dir_q;
    per_d    = arb && req_own != OWN_NONE ? req_per : per_q;
    rem_d    = hi_entry && owner_q == OWN_MAN ? rem_q - WIDTH_WORK'(1) : rem_q;
    pend_d   = pend_q;
    if (arb && pend_q && !man_cont) begin
      rem_d  = psteps_q;
      pend_d = 1'b0;
    end
    if (accept && man_steps != '0) pend_d = 1'b1;
    pdir_d   = accept ? man_dir : pdir_q;
    pper_d   = accept ? man_period : pper_q;
    psteps_d = accept ? man_steps : psteps_q;
    busy_d   = finish ? 1'b0 : (accept && man_steps != '0) ? 1'b1 : busy_q;
    done_d   = finish || (accept && man_steps == '0);
    step_d   = state_d == ST_STEP_HI;
    drv_d    = state_d != ST_IDLE;
    cnt_d    = hi_entry ? cnt_q + WIDTH_WORK'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      dir_q    <= 1'b0;
      per_q    <= '0;
      rem_q    <= '0;
      pend_q   <= 1'b0;
      pdir_q   <= 1'b0;
      pper_q   <= '0;
      psteps_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      step_q   <= 1'b0;
      drv_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      owner_q  <= owner_d;
      dir_q    <= dir_d;
      per_q    <= per_d;
      rem_q    <= rem_d;
      pend_q   <= pend_d;
      pdir_q   <= pdir_d;
      pper_q   <= pper_d;
      psteps_q <= psteps_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      step_q   <= step_d;
      drv_q    <= drv_d;
      cnt_q    <= cnt_d;
    end
  end
  assign man_busy   = busy_q;
  assign man_done   = done_q;
  assign step       = step_q;
  assign dir        = dir_q;
  assign drv_enable = drv_q;
  assign owner      = owner_q;
  assign step_cnt   = cnt_q;
endmodule
